// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - handshaked ALU with single-cycle ops and a sequential restoring divider
// Results are registered and held until the consumer takes them; division takes WIDTH+1 cycles.
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       class_flag,
  output logic             ovf,
  output logic             zero,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic             r_neg, r_dovf;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_class;
  logic             r_ovf, r_zero, r_dz;

  logic             w_accept, w_is_div, w_b_zero, w_load_idle, w_start_div;
  logic [WIDTH-1:0] w_sum, w_diff, w_res, w_a_mag, w_b_mag, w_trial, w_div_q;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ovf, w_ge;
  logic [3:0]       w_class;

  assign in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_is_div    = (ALU_FUN == 4'h3);
  assign w_b_zero    = (B == '0);
  assign w_load_idle = w_accept && (!w_is_div || w_b_zero);
  assign w_start_div = w_accept && w_is_div && !w_b_zero;

  assign w_sum   = A + B;
  assign w_diff  = A - B;
  assign w_prod  = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign w_class = 4'b0001 << ALU_FUN[3:2];

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (ALU_FUN)
      4'h0: begin
        w_res = w_sum;
        w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'h1: begin
        w_res = w_diff;
        w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'h2: begin
        w_res = w_prod[WIDTH-1:0];
        // product fits only if the upper half is a sign extension of bit WIDTH-1
        w_ovf = (|w_prod[2*WIDTH-1:WIDTH-1]) && !(&w_prod[2*WIDTH-1:WIDTH-1]);
      end
      4'h4: w_res = A & B;
      4'h5: w_res = A | B;
      4'h6: w_res = ~(A & B);
      4'h7: w_res = ~(A | B);
      4'h9: w_res = (A == B) ? WIDTH'(1) : '0;
      4'hA: w_res = ($signed(A) > $signed(B)) ? WIDTH'(2) : '0;
      4'hB: w_res = ($signed(A) < $signed(B)) ? WIDTH'(3) : '0;
      4'hC: w_res = A >> 1;
      4'hD: w_res = A << 1;
      4'hE: w_res = B >> 1;
      4'hF: w_res = B << 1;
      default: w_res = '0;
    endcase
  end

  // Magnitude of the most-negative value is representable as an unsigned WIDTH-bit number.
  assign w_a_mag  = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign w_b_mag  = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_trial  = w_rem_sh[WIDTH-1:0] - r_dvs;
  assign w_div_q  = r_neg ? (~r_quo + 1'b1) : r_quo;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_div) w_state_nxt = S_DIV;
      S_DIV:   if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_neg  <= 1'b0;
      r_dovf <= 1'b0;
    end else if (w_start_div) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= w_a_mag;
      r_dvs  <= w_b_mag;
      r_neg  <= A[WIDTH-1] ^ B[WIDTH-1];
      r_dovf <= (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
    end else if (r_state == S_DIV) begin
      r_cnt <= r_cnt + 1'b1;
      r_rem <= w_ge ? w_trial : w_rem_sh[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_class     <= '0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_dz        <= 1'b0;
    end else if (w_load_idle) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_class     <= w_class;
      r_ovf       <= w_ovf;
      r_zero      <= (w_res == '0);
      r_dz        <= w_is_div;
    end else if (r_state == S_FIX) begin
      r_out_valid <= 1'b1;
      r_result    <= w_div_q;
      r_class     <= 4'b0001;
      r_ovf       <= r_dovf;
      r_zero      <= (w_div_q == '0);
      r_dz        <= 1'b0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign class_flag = r_class;
  assign ovf        = r_ovf;
  assign zero       = r_zero;
  assign dz         = r_dz;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed self-checking bench for alu_multicycle
// Inputs are driven and outputs sampled on the falling edge.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic [3:0]  ALU_FUN;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  class_flag;
  logic        ovf, zero, dz;

  int n_checks = 0;
  int n_pass   = 0;

  alu_multicycle #(.WIDTH(16)) dut (
    .clk(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_FUN(ALU_FUN), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .class_flag(class_flag), .ovf(ovf), .zero(zero), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] res, input logic [3:0] cls,
                            input logic o, input logic z, input logic d);
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".result"}, result, res);
    check({tag, ".class"}, class_flag, cls);
    check({tag, ".ovf"}, ovf, o);
    check({tag, ".zero"}, zero, z);
    check({tag, ".dz"}, dz, d);
  endtask

  // Present one operation for a single cycle; returns at the falling edge after the accept edge.
  task automatic issue(input string tag, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    check({tag, ".in_ready"}, in_ready, 1'b1);
    ALU_FUN  = f;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A        = 16'hDEAD;
    B        = 16'hBEEF;
    ALU_FUN  = 4'h0;
  endtask

  // Counts cycles from the accept edge until out_valid, checking in_ready stays low meanwhile.
  task automatic wait_div(input string tag, input int exp_lat);
    int c;
    int busy_violations;
    c = 0;
    busy_violations = 0;
    while (!out_valid && c < 40) begin
      if (in_ready) busy_violations++;
      @(negedge clk);
      c++;
    end
    check({tag, ".latency"}, c, exp_lat);
    check({tag, ".in_ready_busy"}, busy_violations, 0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  initial begin
    int seen_valid;
    RST       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    ALU_FUN   = '0;
    repeat (2) @(negedge clk);
    check("rst.valid", out_valid, 1'b0);
    check("rst.result", result, 16'h0000);
    check("rst.class", class_flag, 4'b0000);
    check("rst.flags", {ovf, zero, dz}, 3'b000);
    RST = 1'b0;
    @(negedge clk);
    check("rst.in_ready", in_ready, 1'b1);

    issue("add", 4'h0, 16'h7FFF, 16'h0001);
    expect_out("add", 16'h8000, 4'b0001, 1'b1, 1'b0, 1'b0);
    issue("sub", 4'h1, 16'h0FFF, 16'h1001);
    expect_out("sub", 16'hFFFE, 4'b0001, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    check("sub.consumed", out_valid, 1'b0);

    issue("div1", 4'h3, 16'hFFF9, 16'h0002);
    wait_div("div1", 17);
    expect_out("div1", 16'hFFFD, 4'b0001, 1'b0, 1'b0, 1'b0);
    issue("div2", 4'h3, 16'h8000, 16'hFFFF);
    wait_div("div2", 17);
    expect_out("div2", 16'h8000, 4'b0001, 1'b1, 1'b0, 1'b0);

    issue("divz", 4'h3, 16'h0005, 16'h0000);
    expect_out("divz", 16'h0000, 4'b0001, 1'b0, 1'b1, 1'b1);
    issue("and", 4'h4, 16'h0004, 16'h0008);
    expect_out("and", 16'h0000, 4'b0010, 1'b0, 1'b1, 1'b0);
    idle_cycle();

    // Back-to-back compares with the consumer stalled for three cycles.
    out_ready = 1'b0;
    issue("cmp9", 4'h9, 16'h0009, 16'h0005);
    expect_out("cmp9", 16'h0000, 4'b0100, 1'b0, 1'b1, 1'b0);
    ALU_FUN  = 4'hA;
    A        = 16'h0009;
    B        = 16'h0005;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("hold.in_ready", in_ready, 1'b0);
      check("hold.result", {out_valid, result}, {1'b1, 16'h0000});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    expect_out("cmpA", 16'h0002, 4'b0100, 1'b0, 1'b0, 1'b0);
    ALU_FUN = 4'hB;
    @(negedge clk);
    expect_out("cmpB", 16'h0000, 4'b0100, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("cmp.drained", out_valid, 1'b0);
    issue("cmpeq", 4'h9, 16'h0009, 16'h0009);
    expect_out("cmpeq", 16'h0001, 4'b0100, 1'b0, 1'b0, 1'b0);
    idle_cycle();

    // Reset in the middle of a division.
    issue("divrst", 4'h3, 16'h0FFF, 16'h0003);
    repeat (8) @(negedge clk);
    check("divrst.busy", in_ready, 1'b0);
    RST = 1'b1;
    #1;
    check("divrst.in_rst", {out_valid, result, class_flag, ovf, zero, dz}, 24'h0);
    @(negedge clk);
    RST = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) seen_valid++;
      @(negedge clk);
    end
    check("divrst.no_result", seen_valid, 0);
    check("divrst.outputs", {result, class_flag, ovf, zero, dz}, 23'h0);
    issue("shl", 4'hD, 16'h0009, 16'h0000);
    expect_out("shl", 16'h0012, 4'b1000, 1'b0, 1'b0, 1'b0);

    issue("mul1", 4'h2, 16'h0FFF, 16'h1001);
    expect_out("mul1", 16'hFFFF, 4'b0001, 1'b1, 1'b0, 1'b0);
    issue("mul2", 4'h2, 16'hFFFF, 16'h0001);
    expect_out("mul2", 16'hFFFF, 4'b0001, 1'b0, 1'b0, 1'b0);
    issue("shrB", 4'hE, 16'h0000, 16'h8002);
    expect_out("shrB", 16'h4001, 4'b1000, 1'b0, 1'b0, 1'b0);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
